stage_wb: RTL
=============

// Module: stage_WB
// PURPOSE
//   MEM/WB pipeline register plus write-back stage of the 5-stage RISC-V core. Sits directly
//   downstream of the MEM stage and captures its result, the loaded word and the control bits.
//   Extracts and extends sub-word loads, selects the write-back value and drives the register
//   file write port, which also serves as the forwarding source. Counts retired instructions.
// PARAMETERS
//   REG_WIDTH        32  datapath width; load extraction requires 32
//   REG_ADDR_WIDTH   5   register-file index width
//   RETIRE_CNT_WIDTH 32  width of the retired-instruction counter
// PORTS
//   clk               in   1    clock, rising edge
//   reset_n           in   1    asynchronous reset, active low
//   stall             in   1    hold MEM/WB register contents
//   flush             in   1    invalidate MEM/WB register contents (bubble)
//   MEM_valid         in   1    MEM-stage slot holds a real instruction
//   MEM_reg_write_en  in   1    instruction writes rd
//   MEM_rd_addr       in   REG_ADDR_WIDTH  destination register
//   MEM_wb_sel        in   2    00 ALU, 01 load, 10 PC+4, 11 ALU
//   MEM_funct3        in   3    load size/sign field
//   MEM_alu_out       in   REG_WIDTH  ALU result / data-memory address
//   DMEM_data_out     in   REG_WIDTH  word read from DMEM (aligned)
//   MEM_pc_plus4      in   REG_WIDTH  link address
//   WB_valid          out  1    WB slot holds a real instruction
//   RF_wr_en          out  1    register-file write enable
//   RF_wr_addr        out  REG_ADDR_WIDTH  register-file write index
//   RF_wr_data        out  REG_WIDTH  register-file write data, also the forwarding value
//   retire_count      out  RETIRE_CNT_WIDTH  retired-instruction count
// BEHAVIOUR
//   - Reset (async, reset_n=0): all MEM/WB register fields = 0, WB_valid=0, retire_count=0.
//     This gives RF_wr_en=0, RF_wr_addr=0 and RF_wr_data=0. Reset mid-stall or mid-flush
//     takes effect immediately.
//   - Register update at posedge clk, with priority flush > stall > load:
//       flush: WB_valid<=0; all other fields don't-care (keep their values).
//       stall: every field holds its value.
//       else:  capture all MEM_* inputs, DMEM_data_out and MEM_alu_out[1:0].
//   - Latency: an instruction's inputs appear on the RF_* outputs one cycle after capture.
//   - Load extraction (combinational from registered data, little-endian; lsb = registered
//     alu_out[1:0]):
//       000 LB : byte[lsb] sign-extended
//       001 LH : half[lsb[1]] sign-extended; lsb[0] is ignored
//       100 LBU: byte[lsb] zero-extended
//       101 LHU: half[lsb[1]] zero-extended
//       010 LW and all other codes: full word
//   - RF_wr_data = wb_sel 01 ? extracted load : wb_sel 10 ? pc_plus4 : alu_out.
//   - RF_wr_en = WB_valid & reg_write_en & (rd != 0); x0 is never written.
//   - While stalled, RF_wr_en stays asserted with the same address and data. Repeated
//     identical writes are legal.
//   - retire_count increments by 1 at a posedge when WB_valid=1 and stall=0 (flush=1 still
//     counts, because the instruction in WB leaves). The counter wraps modulo
//     2^RETIRE_CNT_WIDTH with no saturation.
//   - Fully combinational from registered state to RF_*; no path from MEM_* inputs to outputs.
// TESTING
//   1 Reset: drive valid inputs and assert reset_n=0 mid-cycle -> all outputs 0 at once and
//     stay 0 until the first capture edge after release.
//   2 LB: DMEM=0x80FF1234, alu_out=0x103, funct3=000, wb_sel=01, rd=5 -> next cycle
//     RF_wr_en=1, addr=5, data=0xFFFFFF80. With funct3=101 and alu_out=0x102
//     -> data=0x000080FF.
//   3 wb_sel=10, pc_plus4=0x0000_0044, rd=1 -> data=0x44. Repeat with rd=0 -> RF_wr_en=0
//     and retire_count still increments.
//   4 Stall 3 cycles while inputs change -> RF_* frozen and retire_count unchanged.
//     Then assert stall and flush together -> WB_valid=0 next cycle and retire_count +1.
//   5 RETIRE_CNT_WIDTH=4: retire 17 back-to-back valid instructions -> count reads 0xF,
//     then 0x0, then 0x1.

Source files
------------

// File: rtl/stage_wb.sv
// MEM/WB pipeline register and write-back stage: captures the MEM-stage result,
// extracts sub-word loads, drives the register-file write port and counts retirements.
module stage_wb #(
  parameter int REG_WIDTH        = 32,
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int RETIRE_CNT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        MEM_valid,
  input  logic                        MEM_reg_write_en,
  input  logic [REG_ADDR_WIDTH-1:0]   MEM_rd_addr,
  input  logic [1:0]                  MEM_wb_sel,
  input  logic [2:0]                  MEM_funct3,
  input  logic [REG_WIDTH-1:0]        MEM_alu_out,
  input  logic [REG_WIDTH-1:0]        DMEM_data_out,
  input  logic [REG_WIDTH-1:0]        MEM_pc_plus4,
  output logic                        WB_valid,
  output logic                        RF_wr_en,
  output logic [REG_ADDR_WIDTH-1:0]   RF_wr_addr,
  output logic [REG_WIDTH-1:0]        RF_wr_data,
  output logic [RETIRE_CNT_WIDTH-1:0] retire_count
);

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_ALU2 = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_e;

  logic                      valid_q;
  logic                      reg_write_en_q;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
  wb_sel_e                   wb_sel_q;
  logic [2:0]                funct3_q;
  logic [REG_WIDTH-1:0]      alu_out_q;
  logic [REG_WIDTH-1:0]      dmem_q;
  logic [REG_WIDTH-1:0]      pc_plus4_q;
  logic [RETIRE_CNT_WIDTH-1:0] retire_q;

  // The WB instruction leaves either by advancing normally or by being flushed,
  // and flush wins over stall, so both cases retire it.
  logic retire_now;
  assign retire_now = valid_q & (flush | ~stall);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q        <= 1'b0;
      reg_write_en_q <= 1'b0;
      rd_addr_q      <= '0;
      wb_sel_q       <= WB_ALU;
      funct3_q       <= '0;
      alu_out_q      <= '0;
      dmem_q         <= '0;
      pc_plus4_q     <= '0;
      retire_q       <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (!stall) begin
        valid_q        <= MEM_valid;
        reg_write_en_q <= MEM_reg_write_en;
        rd_addr_q      <= MEM_rd_addr;
        wb_sel_q       <= wb_sel_e'(MEM_wb_sel);
        funct3_q       <= MEM_funct3;
        alu_out_q      <= MEM_alu_out;
        dmem_q         <= DMEM_data_out;
        pc_plus4_q     <= MEM_pc_plus4;
      end
      if (retire_now) retire_q <= retire_q + RETIRE_CNT_WIDTH'(1);
    end
  end

  logic [1:0]           lsb;
  logic [7:0]           load_byte;
  logic [15:0]          load_half;
  logic [REG_WIDTH-1:0] load_data;

  assign lsb       = alu_out_q[1:0];
  assign load_byte = dmem_q[8*lsb +: 8];
  assign load_half = dmem_q[16*lsb[1] +: 16];

  // NOTE: every combinational output gets a default first so no path through
  // the case statements can infer a latch.
  always_comb begin
    load_data = dmem_q;
    case (funct3_e'(funct3_q))
      F3_LB:   load_data = {{(REG_WIDTH-8){load_byte[7]}}, load_byte};
      F3_LH:   load_data = {{(REG_WIDTH-16){load_half[15]}}, load_half};
      F3_LBU:  load_data = {{(REG_WIDTH-8){1'b0}}, load_byte};
      F3_LHU:  load_data = {{(REG_WIDTH-16){1'b0}}, load_half};
      default: load_data = dmem_q;
    endcase
  end

  always_comb begin
    RF_wr_data = alu_out_q;
    case (wb_sel_q)
      WB_LOAD: RF_wr_data = load_data;
      WB_PC4:  RF_wr_data = pc_plus4_q;
      default: RF_wr_data = alu_out_q;
    endcase
  end

  // x0 is hard-wired to zero, so writes to it are suppressed here.
  assign WB_valid     = valid_q;
  assign RF_wr_en     = valid_q & reg_write_en_q & (|rd_addr_q);
  assign RF_wr_addr   = rd_addr_q;
  assign retire_count = retire_q;

endmodule
